// File: rtl/sign_extender_12to16_pkg.sv
// Shared constants and mode encodings for the 12-to-16 bit immediate widener.
package sign_extender_12to16_pkg;

  localparam int IN_W  = 12;
  localparam int OUT_W = 16;

  typedef enum logic [1:0] {
    MODE_SEXT     = 2'b00,
    MODE_ZEXT     = 2'b01,
    MODE_SEXT_SL1 = 2'b10,
    MODE_UPPER    = 2'b11
  } mode_e;

  // Replicates the sign bit of an immediate into an n-bit fill pattern
  // (returned right-aligned in a 4-bit field).
  function automatic logic [3:0] sign_fill(input logic sign);
    return sign ? 4'b1111 : 4'b0000;
  endfunction

endpackage

// File: rtl/sign_extender_12to16_sext_core.sv
// Combinational mode mux that widens a 12-bit immediate to 16 bits.
// Only in_i[11] drives the fill in the sign-extending modes.
module sext_core
  import sign_extender_12to16_pkg::*;
(
  input  logic [IN_W-1:0]  in_i,
  input  logic [1:0]       mode_i,
  output logic [OUT_W-1:0] out_o
);

  logic [3:0] fill_s;

  assign fill_s = sign_fill(in_i[IN_W-1]);

  // Select the widened value for the requested extension mode.
  always_comb begin
    out_o = {fill_s, in_i};
    case (mode_e'(mode_i))
      MODE_SEXT:     out_o = {fill_s, in_i};
      MODE_ZEXT:     out_o = {4'b0000, in_i};
      MODE_SEXT_SL1: out_o = {fill_s[2:0], in_i, 1'b0};
      MODE_UPPER:    out_o = {in_i, 4'b0000};
      default:       out_o = {fill_s, in_i};
    endcase
  end

endmodule

// File: rtl/sign_extender_12to16.sv
// Immediate widener: combinational result for the ALU operand mux plus a
// valid-qualified registered copy for pipelined consumers.
module sign_extender_12to16
  import sign_extender_12to16_pkg::*;
#(
  parameter int IN_W  = 12,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic [OUT_W-1:0] out,
  output logic [OUT_W-1:0] out_q,
  output logic             out_valid
);

  logic [OUT_W-1:0] ext_s;
  logic [OUT_W-1:0] out_q_d;
  logic [OUT_W-1:0] out_q_q;
  logic             out_valid_q;

  sext_core u_sext_core (
    .in_i   (in),
    .mode_i (mode),
    .out_o  (ext_s)
  );

  assign out = ext_s;

  // Capture the widened value only on qualified transfers; otherwise hold.
  always_comb begin
    if (in_valid) begin
      out_q_d = ext_s;
    end else begin
      out_q_d = out_q_q;
    end
  end

  // Register stage; reset wins over any transfer presented in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q_q     <= 16'h0000;
      out_valid_q <= 1'b0;
    end else begin
      out_q_q     <= out_q_d;
      out_valid_q <= in_valid;
    end
  end

  assign out_q     = out_q_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sign_extender_12to16.sv
// Self-checking bench for sign_extender_12to16: directed vectors, reset,
// streaming and an exhaustive sweep, with a queue scoreboard on out_q.
module tb_sign_extender_12to16;

  logic        clk;
  logic        rst_n;
  logic [11:0] in;
  logic [1:0]  mode;
  logic        in_valid;
  logic [15:0] out;
  logic [15:0] out_q;
  logic        out_valid;

  int errors;
  int checks;

  logic [15:0] sb_q[$];
  logic [15:0] last_q;

  sign_extender_12to16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .mode      (mode),
    .in_valid  (in_valid),
    .out       (out),
    .out_q     (out_q),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model written arithmetically rather than as a bit mux.
  function automatic logic [15:0] ref_ext(input logic [11:0] v, input logic [1:0] m);
    logic [15:0] s;
    s = {4'h0, v};
    if (v[11]) s = s | 16'hF000;
    case (m)
      2'b00:   return s;
      2'b01:   return {4'h0, v};
      2'b10:   return s << 1;
      default: return {4'h0, v} << 4;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock of stimulus: drive at negedge, check comb output, then the
  // registered outputs just after the following posedge.
  task automatic step(input logic [11:0] v, input logic [1:0] m, input logic vld,
                      input logic [15:0] exp, input string tag);
    logic [15:0] e;
    @(negedge clk);
    in = v; mode = m; in_valid = vld;
    #1;
    chk({tag, "_comb"}, out, exp);
    if (vld) sb_q.push_back(exp);
    @(posedge clk);
    #1;
    chk({tag, "_vld"}, {15'd0, out_valid}, {15'd0, vld});
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        chk({tag, "_sbempty"}, 16'd0, 16'd1);
      end else begin
        e = sb_q.pop_front();
        chk({tag, "_outq"}, out_q, e);
        last_q = e;
      end
    end else begin
      chk({tag, "_hold"}, out_q, last_q);
    end
  endtask

  task automatic comb(input logic [11:0] v, input logic [1:0] m,
                      input logic [15:0] exp, input string tag);
    in = v; mode = m;
    #1;
    chk(tag, out, exp);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    last_q = 16'h0000;
    rst_n = 1'b0;
    in = 12'h000; mode = 2'b00; in_valid = 1'b0;

    // Directed combinational vectors
    comb(12'h000, 2'b00, 16'h0000, "s00_000");
    comb(12'h001, 2'b00, 16'h0001, "s00_001");
    comb(12'h800, 2'b00, 16'hF800, "s00_800");
    comb(12'hFFF, 2'b00, 16'hFFFF, "s00_fff");
    comb(12'h911, 2'b00, 16'hF911, "s00_911");
    comb(12'h800, 2'b01, 16'h0800, "m01_800");
    comb(12'h800, 2'b10, 16'hF000, "m10_800");
    comb(12'h800, 2'b11, 16'h8000, "m11_800");
    comb(12'h123, 2'b00, 16'h0123, "m00_123");
    comb(12'h123, 2'b10, 16'h0246, "m10_123");
    comb(12'h123, 2'b11, 16'h1230, "m11_123");
    comb(12'h7FF, 2'b00, 16'h07FF, "m00_7ff");

    // Reset held with a valid transfer presented
    @(negedge clk);
    in = 12'hFFF; mode = 2'b00; in_valid = 1'b1; rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_outq", out_q, 16'h0000);
    chk("rst_vld", {15'd0, out_valid}, 16'd0);
    chk("rst_comb", out, 16'hFFFF);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    last_q = 16'h0000;

    // Streaming back-to-back then drop valid
    step(12'h001, 2'b00, 1'b1, 16'h0001, "str0");
    step(12'h800, 2'b00, 1'b1, 16'hF800, "str1");
    step(12'h911, 2'b00, 1'b1, 16'hF911, "str2");
    step(12'h123, 2'b11, 1'b0, 16'h1230, "drop0");
    step(12'h456, 2'b01, 1'b0, 16'h0456, "drop1");
    chk("drop_hold", out_q, 16'hF911);

    // Reset mid-stream drops the concurrent transfer
    step(12'h321, 2'b00, 1'b1, 16'h0321, "pre_rst");
    @(negedge clk);
    in = 12'hABC; mode = 2'b11; in_valid = 1'b1; rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_outq", out_q, 16'h0000);
    chk("midrst_vld", {15'd0, out_valid}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    last_q = 16'h0000;

    // Exhaustive sweep on both paths, with an idle cycle after each mode
    for (int m = 0; m < 4; m++) begin
      for (int v = 0; v < 4096; v++) begin
        step(v[11:0], m[1:0], 1'b1, ref_ext(v[11:0], m[1:0]), "exh");
      end
      step(12'h5A5, m[1:0], 1'b0, ref_ext(12'h5A5, m[1:0]), "exh_idle");
    end

    chk("sb_drained", 16'(sb_q.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sign_extender_12to16.md
# sign_extender_12to16

Widens a 12-bit immediate field to the 16-bit datapath width for the processor's immediate path. It provides a combinational result for same-cycle use by the ALU operand mux. It also provides a registered, valid-qualified copy for pipelined consumers. Default mode is two's-complement sign extension; three auxiliary modes cover zero-extension, word-scaled offsets and upper-immediate placement.

## Interface
Parameters:
- IN_W, 12, input field width (fixed at 12 for this block).
- OUT_W, 16, output width (fixed at 16).

Ports (one clock; reset is synchronous and active-low):
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in  input  12  immediate field.
- mode  input  2  extension mode; 2'b00 is the default and must be driven to 00 when unused.
- in_valid  input  1  qualifies `in`/`mode` for the registered path.
- out  output  16  combinational result.
- out_q  output  16  registered result.
- out_valid  output  1  qualifies `out_q`.

## Operation
- mode 2'b00, sign-extend: out = {{4{in[11]}}, in}.
- mode 2'b01, zero-extend: out = {4'b0000, in}.
- mode 2'b10, sign-extend then shift left 1: out = {{3{in[11]}}, in, 1'b0}.
  - in[11] is replicated into bits 15:13.
  - Bit 0 is always 0.
- mode 2'b11, upper placement: out = {in, 4'b0000}.
- `out` is purely combinational from `in` and `mode`.
  - It has no dependence on clk or rst_n.
  - It is valid within the same delta after the inputs change.
- No X propagation beyond the inputs. Every bit of `out` is defined for every defined `in`/`mode`.
- Bit 11 is the sign bit for modes 00 and 10. Only in[11] determines the fill; lower bits never affect it.
- Registered path:
  - On a rising clk edge with rst_n=1 and in_valid=1: out_q <= out.
  - On a rising clk edge with rst_n=1 and in_valid=0: out_q holds its value.
  - out_valid <= in_valid on every rising edge with rst_n=1.

## Timing
- Combinational latency: 0 cycles for `out`.
- Registered latency: 1 cycle. Inputs sampled at edge N appear on out_q/out_valid after edge N.
- Reset values: out_q = 16'h0000, out_valid = 0. `out` is unaffected by reset.
- Reset applies only at a rising edge with rst_n=0, and it overrides in_valid.
- Reset mid-stream: a transfer presented in the same cycle as reset is dropped.
- Back-to-back: in_valid held high for K cycles yields K consecutive out_valid cycles, each carrying the corresponding input. No bubbles and no backpressure.
- Mode changes take effect immediately on `out`. They take effect on out_q at the next qualifying edge.

## Structure
- Shared package:
  - mode encodings MODE_SEXT=2'b00, MODE_ZEXT=2'b01, MODE_SEXT_SL1=2'b10, MODE_UPPER=2'b11.
  - IN_W/OUT_W constants.
- One natural sub-module, `sext_core`: the combinational mode mux producing `out`.
- The top level instantiates `sext_core` and adds the out_q/out_valid register stage.

## Test plan
- mode=00, combinational:
  - in=12'h000 -> out=16'h0000.
  - in=12'h001 -> out=16'h0001.
  - in=12'h800 -> out=16'hF800.
  - in=12'hFFF -> out=16'hFFFF.
  - in=12'h911 -> out=16'hF911.
- Mode sweep with in=12'h800:
  - mode=01 -> 16'h0800.
  - mode=10 -> 16'hF000.
  - mode=11 -> 16'h8000.
- Mode sweep with in=12'h123:
  - mode=00 -> 16'h0123.
  - mode=10 -> 16'h0246.
  - mode=11 -> 16'h1230.
- Reset: hold rst_n=0 with in_valid=1 and in=12'hFFF for 2 edges -> out_q=16'h0000, out_valid=0. Meanwhile out=16'hFFFF.
- Registered streaming, mode=00:
  - Drive in=12'h001, 12'h800, 12'h911 on 3 consecutive edges with in_valid=1.
  - Required: out_q=16'h0001, 16'hF800, 16'hF911 on the following edges, with out_valid=1 throughout.
  - Then drop in_valid: out_valid=0 and out_q holds 16'hF911.
- Exhaustive: all 4096 `in` values × 4 modes compared against the Operation formulas, on both the combinational and registered paths.
